seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
// - Serial pattern generator: accepts a bit pattern, its length and a repeat count via valid/ready,
//   then streams the pattern MSB-first, one bit per clock, with an out_valid qualifier.
// - Transmit-side companion to the serial sequence detectors. Drives their `in` input for
//   stimulus and for built-in self-test of detector chains.
// PARAMETERS
// - MAX_LEN  16                     max pattern length in bits
// - LEN_W    $clog2(MAX_LEN+1) (5)  width of pat_len
// - REP_W    4                      width of pat_reps; pattern is emitted pat_reps+1 times
// PORTS
// - clk        in   1        single clock; all logic on posedge
// - rst_n      in   1        asynchronous, active-low reset
// - pat_valid  in   1        pattern request valid
// - pat_ready  out  1        block can accept a pattern
// - pat_data   in   MAX_LEN  pattern; bits [pat_len-1:0] used, bit pat_len-1 sent first
// - pat_len    in   LEN_W    pattern length; legal range 1..MAX_LEN
// - pat_reps   in   REP_W    extra repetitions, 0 = send once
// - abort      in   1        synchronous stream cancel
// - out_bit    out  1        serial data; 0 whenever out_valid=0
// - out_valid  out  1        out_bit is a pattern bit this cycle
// - busy       out  1        streaming in progress (state SHIFT)
// - done       out  1        1-cycle pulse after the last bit of a completed stream
// - err_len    out  1        1-cycle pulse when an illegal pat_len is accepted
// BEHAVIOUR
// - Reset (async, any time incl. mid-stream): state=IDLE; out_bit=out_valid=busy=done=err_len=0;
//   internal shift reg, bit and rep counters cleared. pat_ready=1 after reset release.
// - All outputs registered, except pat_ready = (state==IDLE) && !abort.
// - FSM states: IDLE, SHIFT.
//   - IDLE->SHIFT on handshake (pat_valid && pat_ready) with 1<=pat_len<=MAX_LEN.
//     Capture pat_data, pat_len, pat_reps.
//   - Handshake with pat_len==0 or pat_len>MAX_LEN: request consumed, err_len=1 next cycle,
//     stay IDLE, no bits emitted, no done.
//   - SHIFT: each cycle emit the next bit.
//     - After bit pat_len of a pass with reps remaining: reload from the captured pattern,
//       decrement rep count, no idle gap between passes.
//     - After the final bit: SHIFT->IDLE.
// - Latency: handshake in cycle N -> first bit (out_valid=1) in cycle N+1.
//   Stream is exactly pat_len*(pat_reps+1) contiguous valid cycles.
//   done=1 in the cycle after the last bit, with out_valid=0 and pat_ready=1.
// - Back-to-back: a handshake in the done cycle is accepted. Minimum gap between streams is
//   exactly 1 cycle, the done/handshake cycle.
// - abort:
//   - In SHIFT: next cycle out_valid=0, busy=0, state=IDLE; no done; remaining bits discarded.
//   - In IDLE: pat_ready=0, so no handshake can occur. Otherwise no effect.
//   - In the cycle of the last bit: abort wins, no done pulse.
// - Counters: bit counter LEN_W bits, down-count from pat_len to 1. Rep counter REP_W bits,
//   down to 0. No wrap: the max value 2^REP_W-1 is legal and gives 2^REP_W passes.
// - pat_data bits above pat_len-1 are ignored.
// STRUCTURE
// - Package seq_pkg:
//   - typedef enum logic {IDLE, SHIFT} seq_gen_state_t
//   - localparam SEQ_MAX_LEN = 16 (shared with detector-side benches)
// - Sub-module seq_down_counter (WIDTH param; load, dec, zero flag). Instanced twice: bit and
//   rep counters. Shift reg and FSM stay in the top level.
// TESTING
// - Single stream: data=4'b1011, len=4, reps=0 -> out_bit 1,0,1,1 in cycles N+1..N+4;
//   done at N+5; pat_ready high at N+5.
// - Repeat into detector: data=2'b11, len=2, reps=2 -> six contiguous 1s.
//   An attached "11" Mealy detector gives z=1 on bits 2..6 (5 pulses).
// - Illegal length: len=0, then len=17 -> err_len pulses at N+1 each; out_valid stays 0; no done.
// - Abort: data=8'hA5, len=8, abort asserted with the 3rd bit -> bits 1,0,1 seen;
//   out_valid=0 next cycle; no done; pat_ready=1.
// - Back-to-back: pat_valid held high with 3'b110 then 2'b01 -> 1,1,0, one gap cycle
//   (done=1), then 0,1.
// - Reset mid-stream: rst_n low during bit 5 of a 16-bit pattern -> all outputs 0 immediately;
//   after release a new 4-bit pattern streams correctly from its MSB.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and the detector-side benches.
package seq_pkg;

  localparam int SEQ_MAX_LEN = 16;

  typedef enum logic {IDLE, SHIFT} seq_gen_state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping.
// tc_o flags when the count equals TERM; with the default TERM it is a plain zero flag.
module seq_down_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TERM  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: streams a captured pattern MSB-first, pat_reps+1 times, one bit per clock.
// state | meaning
// IDLE  | waiting for a pattern request; pat_ready high unless abort
// SHIFT | emitting pattern bits, out_valid high every cycle
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int REP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pat_valid,
  output logic               pat_ready,
  input  logic [MAX_LEN-1:0] pat_data,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [REP_W-1:0]   pat_reps,
  input  logic               abort,
  output logic               out_bit,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic               err_len
);

  seq_gen_state_t     state_q, state_d;
  logic [MAX_LEN-1:0] shreg_q, shreg_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               out_bit_q, out_bit_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               handshake;
  logic               len_ok;
  logic [MAX_LEN-1:0] pat_aligned;
  logic               bit_load, bit_dec, bit_last;
  logic               rep_load, rep_dec, rep_zero;
  logic [LEN_W-1:0]   bit_load_val;

  assign pat_ready = (state_q == IDLE) && !abort;
  assign handshake = pat_valid && pat_ready;
  assign len_ok    = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  // Left-align so the first bit to send always sits at the MSB; unused high bits shift out.
  assign pat_aligned  = pat_data << (LEN_W'(MAX_LEN) - pat_len);
  assign bit_load_val = (state_q == IDLE) ? pat_len : len_q;

  // The bit counter shows the bits left in the pass including the one on out_bit, so 1 marks the last.
  seq_down_counter #(
    .WIDTH (LEN_W),
    .TERM  (LEN_W'(1))
  ) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (bit_load),
    .load_val_i (bit_load_val),
    .dec_i      (bit_dec),
    .tc_o       (bit_last)
  );

  seq_down_counter #(
    .WIDTH (REP_W)
  ) u_rep_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (rep_load),
    .load_val_i (pat_reps),
    .dec_i      (rep_dec),
    .tc_o       (rep_zero)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    pat_d       = pat_q;
    len_d       = len_q;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    bit_load    = 1'b0;
    bit_dec     = 1'b0;
    rep_load    = 1'b0;
    rep_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          if (len_ok) begin
            state_d     = SHIFT;
            pat_d       = pat_aligned;
            len_d       = pat_len;
            out_bit_d   = pat_aligned[MAX_LEN-1];
            out_valid_d = 1'b1;
            shreg_d     = pat_aligned << 1;
            bit_load    = 1'b1;
            rep_load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_last) begin
          if (rep_zero) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            out_bit_d   = pat_q[MAX_LEN-1];
            out_valid_d = 1'b1;
            shreg_d     = pat_q << 1;
            bit_load    = 1'b1;
            rep_dec     = 1'b1;
          end
        end else begin
          out_bit_d   = shreg_q[MAX_LEN-1];
          out_valid_d = 1'b1;
          shreg_d     = shreg_q << 1;
          bit_dec     = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: expected bits are queued when a pattern is sent and
// popped by a negedge monitor whenever out_valid is high.
module tb_seq_pattern_gen;
  import seq_pkg::*;

  localparam int MAX_LEN = SEQ_MAX_LEN;
  localparam int LEN_W   = 5;
  localparam int REP_W   = 4;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b1;
  logic               pat_valid = 1'b0;
  logic [MAX_LEN-1:0] pat_data  = '0;
  logic [LEN_W-1:0]   pat_len   = '0;
  logic [REP_W-1:0]   pat_reps  = '0;
  logic               abort     = 1'b0;
  logic               pat_ready;
  logic               out_bit;
  logic               out_valid;
  logic               busy;
  logic               done;
  logic               err_len;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   det_cnt  = 0;
  int   vld_cnt  = 0;
  logic det_prev = 1'b0;
  logic exp_q[$];

  seq_pattern_gen #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .REP_W   (REP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_data  (pat_data),
    .pat_len   (pat_len),
    .pat_reps  (pat_reps),
    .abort     (abort),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer plus a behavioural "11" Mealy detector on the serial stream.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("out_bit", 32'(out_bit), 32'(exp_q.pop_front()));
        end
        if (det_prev && out_bit) det_cnt++;
        det_prev = out_bit;
      end else begin
        chk("idle_bit_zero", 32'(out_bit), 32'd0);
        det_prev = 1'b0;
      end
      if (done === 1'b1) done_cnt++;
      if (err_len === 1'b1) err_cnt++;
    end
  end

  task automatic push_bits(input logic [15:0] d, input int len, input int reps);
    for (int r = 0; r <= reps; r++)
      for (int i = len - 1; i >= 0; i--)
        exp_q.push_back(d[i]);
  endtask

  // Holds the request until pat_ready is seen, completes the handshake, returns in cycle N+1.
  task automatic send(input logic [15:0] d, input logic [4:0] len, input logic [3:0] reps);
    pat_data  = d;
    pat_len   = len;
    pat_reps  = reps;
    pat_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && pat_ready !== 1'b1; i++) @(negedge clk);
    chk("send_ready", 32'(pat_ready), 32'd1);
    @(posedge clk);
    #1 pat_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int  c    = 0;
    logic seen = 1'b0;
    for (int i = 1; i <= exp_cycles + 20 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        c    = i;
      end
    end
    chk({tag, "_done_cycle"}, 32'(c), 32'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0, e0, v0;
    logic [3:0]  t1_bits;
    logic [6:0]  b2b_vld;
    logic [6:0]  b2b_done;
    t1_bits  = 4'b1011;
    b2b_vld  = 7'b1110110;
    b2b_done = 7'b0001001;

    // reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_bit",   32'(out_bit),   32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err_len",   32'(err_len),   32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(pat_ready), 32'd1);
    @(posedge clk); #1;

    // single stream 1011
    push_bits(16'h000B, 4, 0);
    send(16'h000B, 5'd4, 4'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_bit",   32'(out_bit),   32'(t1_bits[3-k]));
    end
    @(negedge clk);
    chk("t1_done",      32'(done),      32'd1);
    chk("t1_done_vld",  32'(out_valid), 32'd0);
    chk("t1_done_rdy",  32'(pat_ready), 32'd1);
    @(posedge clk); #1;

    // repeated 11 into the detector model
    det_cnt = 0;
    v0 = vld_cnt;
    push_bits(16'h0003, 2, 2);
    send(16'h0003, 5'd2, 4'd2);
    wait_done("t2", 7);
    @(posedge clk); #1;
    chk("t2_det_pulses", 32'(det_cnt),      32'd5);
    chk("t2_valid_cnt",  32'(vld_cnt - v0), 32'd6);

    // illegal lengths
    d0 = done_cnt;
    e0 = err_cnt;
    send(16'hFFFF, 5'd0, 4'd0);
    @(negedge clk);
    chk("t3a_err",   32'(err_len),   32'd1);
    chk("t3a_vld",   32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t3a_err_1cyc", 32'(err_len), 32'd0);
    @(posedge clk); #1;
    send(16'hFFFF, 5'd17, 4'd3);
    @(negedge clk);
    chk("t3b_err",   32'(err_len),   32'd1);
    chk("t3b_busy",  32'(busy),      32'd0);
    @(negedge clk);
    chk("t3b_err_1cyc", 32'(err_len), 32'd0);
    @(posedge clk); #1;
    chk("t3_err_cnt",  32'(err_cnt - e0),  32'd2);
    chk("t3_no_done",  32'(done_cnt - d0), 32'd0);

    // abort with the third bit
    d0 = done_cnt;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    send(16'h00A5, 5'd8, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("t4_ready_in_shift", 32'(pat_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t4_vld",   32'(out_valid), 32'd0);
    chk("t4_busy",  32'(busy),      32'd0);
    chk("t4_ready", 32'(pat_ready), 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t4_queue",   32'(exp_q.size()),  32'd0);

    // abort while idle blocks the handshake
    abort     = 1'b1;
    pat_data  = 16'h000F;
    pat_len   = 5'd4;
    pat_reps  = 4'd0;
    pat_valid = 1'b1;
    @(negedge clk);
    chk("t4_idle_ready", 32'(pat_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    pat_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    chk("t4_idle_vld",  32'(out_valid), 32'd0);
    chk("t4_idle_busy", 32'(busy),      32'd0);
    @(posedge clk); #1;

    // back-to-back with pat_valid held high
    push_bits(16'h0006, 3, 0);
    push_bits(16'h0001, 2, 0);
    pat_data  = 16'h0006;
    pat_len   = 5'd3;
    pat_reps  = 4'd0;
    pat_valid = 1'b1;
    @(negedge clk);
    chk("t5_ready", 32'(pat_ready), 32'd1);
    @(posedge clk); #1;
    pat_data = 16'h0001;
    pat_len  = 5'd2;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t5_vld",  32'(out_valid), 32'(b2b_vld[6-k]));
      chk("t5_done", 32'(done),      32'(b2b_done[6-k]));
      if (k == 3) begin
        chk("t5_gap_ready", 32'(pat_ready), 32'd1);
        @(posedge clk);
        #1 pat_valid = 1'b0;
      end
    end
    @(posedge clk); #1;

    // reset during bit 5 of a 16-bit pattern
    push_bits(16'h000B, 4, 0);
    send(16'hB3C5, 5'd16, 4'd0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld",   32'(out_valid), 32'd0);
    chk("t6_bit",   32'(out_bit),   32'd0);
    chk("t6_busy",  32'(busy),      32'd0);
    chk("t6_done",  32'(done),      32'd0);
    chk("t6_err",   32'(err_len),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t6_queue", 32'(exp_q.size()), 32'd0);
    push_bits(16'h0006, 4, 0);
    send(16'hFFF6, 5'd4, 4'd0);
    wait_done("t6_after", 5);
    @(posedge clk); #1;

    // boundaries: maximum repeat count and maximum length
    v0 = vld_cnt;
    push_bits(16'h0001, 1, 15);
    send(16'h0001, 5'd1, 4'd15);
    wait_done("t7_reps", 17);
    @(posedge clk); #1;
    chk("t7_reps_vld", 32'(vld_cnt - v0), 32'd16);
    v0 = vld_cnt;
    push_bits(16'h8001, 16, 0);
    send(16'h8001, 5'd16, 4'd0);
    wait_done("t7_len", 17);
    @(posedge clk); #1;
    chk("t7_len_vld", 32'(vld_cnt - v0), 32'd16);

    chk("leftover_bits", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
